// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the trace-to-cache dispatcher:
//   - trace command codes as produced by the trace-file reader (4 bits wide)
//   - cache_op_t, the operation encoding presented to the L3 cache model
//   - decode_trace(): maps a raw trace code to {legal, cache_op_t}
// -----------------------------------------------------------------------------
package cache_pkg;

   localparam int TRACE_W = 4;

   localparam logic [TRACE_W-1:0] TR_CPU_READ_DATA  = 4'd0;
   localparam logic [TRACE_W-1:0] TR_CPU_WRITE      = 4'd1;
   localparam logic [TRACE_W-1:0] TR_CPU_READ_INSTR = 4'd2;
   localparam logic [TRACE_W-1:0] TR_SNP_INV        = 4'd3;
   localparam logic [TRACE_W-1:0] TR_SNP_READ       = 4'd4;
   localparam logic [TRACE_W-1:0] TR_SNP_WRITE      = 4'd5;
   localparam logic [TRACE_W-1:0] TR_SNP_RWIM       = 4'd6;
   localparam logic [TRACE_W-1:0] TR_CLEAR          = 4'd8;
   localparam logic [TRACE_W-1:0] TR_PRINT          = 4'd9;

   typedef enum logic [2:0] {
      OP_READ      = 3'd0,
      OP_WRITE     = 3'd1,
      OP_SNP_INV   = 3'd2,
      OP_SNP_READ  = 3'd3,
      OP_SNP_WRITE = 3'd4,
      OP_SNP_RWIM  = 3'd5,
      OP_PRINT     = 3'd6,
      OP_CLEAR     = 3'd7
   } cache_op_t;

   typedef struct packed {
      logic      legal;
      cache_op_t op;
   } trace_dec_t;

   function automatic trace_dec_t decode_trace(input logic [TRACE_W-1:0] code);
      trace_dec_t d;
      d.legal = 1'b1;
      d.op    = OP_READ;
      case (code)
         TR_CPU_READ_DATA,
         TR_CPU_READ_INSTR: d.op = OP_READ;
         TR_CPU_WRITE:      d.op = OP_WRITE;
         TR_SNP_INV:        d.op = OP_SNP_INV;
         TR_SNP_READ:       d.op = OP_SNP_READ;
         TR_SNP_WRITE:      d.op = OP_SNP_WRITE;
         TR_SNP_RWIM:       d.op = OP_SNP_RWIM;
         TR_CLEAR:          d.op = OP_CLEAR;
         TR_PRINT:          d.op = OP_PRINT;
         default:           d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO holding decoded cache commands, DEPTH x WIDTH bits.
// Read data is the current head entry (first-word fall-through).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (pointers only)
//   push_i, wdata_i   write request and data; ignored when full
//   pop_i             remove head entry; ignored when empty
//   rdata_o           head entry
//   full_o, empty_o   occupancy flags
// -----------------------------------------------------------------------------
module cmd_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0] wr_ptr_q, rd_ptr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_i && !empty_o)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/cache_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// cache_cmd_dispatcher
// Accepts raw trace commands, queues the legal ones, issues them one at a time
// to the L3 cache model over a req/ack handshake and keeps per-class counters.
// On end-of-trace it waits for the queue and the cache to drain and pulses
// stats_valid.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          trace command handshake
//   in_cmd, in_addr            raw trace code and address
//   eof                        end of trace (level or pulse, rising edge used)
//   c_req/c_ack                cache operation handshake
//   c_op, c_addr               operation (cache_op_t) and address
//   c_hit                      hit/miss, meaningful with c_req && c_ack
//   rd_cnt .. drop_cnt         statistics counters
//   stats_valid                one-cycle pulse once the trace has drained
//   busy                       queue non-empty or request outstanding
// Build option: SAT_COUNT_EN makes counters saturate instead of wrapping.
// -----------------------------------------------------------------------------
module cache_cmd_dispatcher
   import cache_pkg::*;
#(
   parameter int ADR_BITS = 32,
   parameter int QDEPTH   = 4,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          in_cmd,
   input  logic [ADR_BITS-1:0] in_addr,
   input  logic                eof,
   output logic                c_req,
   output logic [2:0]          c_op,
   output logic [ADR_BITS-1:0] c_addr,
   input  logic                c_ack,
   input  logic                c_hit,
   output logic [CNT_W-1:0]    rd_cnt,
   output logic [CNT_W-1:0]    wr_cnt,
   output logic [CNT_W-1:0]    hit_cnt,
   output logic [CNT_W-1:0]    miss_cnt,
   output logic [CNT_W-1:0]    snoop_cnt,
   output logic [CNT_W-1:0]    drop_cnt,
   output logic                stats_valid,
   output logic                busy
);

   localparam int EW = 3 + ADR_BITS;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef SAT_COUNT_EN
      return (&v) ? v : v + CNT_ONE;
`else
      return v + CNT_ONE;
`endif
   endfunction

   state_t              state_q, state_d;
   cache_op_t           c_op_q, c_op_d;
   logic [ADR_BITS-1:0] c_addr_q, c_addr_d;
   logic                eof_pend_q, eof_pend_d;
   logic                eof_prev_q;
   logic [CNT_W-1:0]    rd_q, rd_d, wr_q, wr_d, hit_q, hit_d;
   logic [CNT_W-1:0]    miss_q, miss_d, snp_q, snp_d, drop_q, drop_d;

   trace_dec_t          dec;
   logic                accept, push, drop, pop, ack, stats_fire;
   logic                fifo_full, fifo_empty;
   logic [EW-1:0]       fifo_rdata;
   cache_op_t           head_op;
   logic [ADR_BITS-1:0] head_addr;

   // Accept / decode
   assign dec      = decode_trace(in_cmd);
   assign in_ready = !fifo_full && !eof_pend_q;
   assign accept   = in_valid && in_ready;
   assign push     = accept && dec.legal;
   assign drop     = accept && !dec.legal;

   cmd_fifo #(
      .WIDTH (EW),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i ({dec.op, in_addr}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_op   = cache_op_t'(fifo_rdata[EW-1:ADR_BITS]);
   assign head_addr = fifo_rdata[ADR_BITS-1:0];

   // Issue FSM
   assign ack = (state_q == ST_ISSUE) && c_ack;

   always_comb begin
      state_d  = state_q;
      c_op_d   = c_op_q;
      c_addr_d = c_addr_q;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               c_op_d   = head_op;
               c_addr_d = head_addr;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (c_ack) begin
               // Chain straight into the next entry so c_req never drops
               // while work is queued.
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  c_op_d   = head_op;
                  c_addr_d = head_addr;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // End-of-trace tracking
   assign stats_fire = eof_pend_q && fifo_empty && (state_q == ST_IDLE);

   always_comb begin
      eof_pend_d = eof_pend_q;
      if (stats_fire)
         eof_pend_d = 1'b0;
      else if (eof && !eof_prev_q)
         eof_pend_d = 1'b1;
   end

   // Statistics
   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      hit_d  = hit_q;
      miss_d = miss_q;
      snp_d  = snp_q;
      drop_d = drop_q;
      if (drop) drop_d = cnt_inc(drop_q);
      if (ack) begin
         case (c_op_q)
            OP_READ, OP_WRITE: begin
               if (c_op_q == OP_READ) rd_d = cnt_inc(rd_q);
               else                   wr_d = cnt_inc(wr_q);
               if (c_hit) hit_d  = cnt_inc(hit_q);
               else       miss_d = cnt_inc(miss_q);
            end
            OP_SNP_INV, OP_SNP_READ, OP_SNP_WRITE, OP_SNP_RWIM:
               snp_d = cnt_inc(snp_q);
            OP_CLEAR: begin
               // Placed after the drop update so a same-edge drop is lost.
               rd_d   = '0;
               wr_d   = '0;
               hit_d  = '0;
               miss_d = '0;
               snp_d  = '0;
               drop_d = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         c_op_q     <= OP_READ;
         c_addr_q   <= '0;
         eof_pend_q <= 1'b0;
         eof_prev_q <= 1'b0;
         rd_q       <= '0;
         wr_q       <= '0;
         hit_q      <= '0;
         miss_q     <= '0;
         snp_q      <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         c_op_q     <= c_op_d;
         c_addr_q   <= c_addr_d;
         eof_pend_q <= eof_pend_d;
         eof_prev_q <= eof;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         snp_q      <= snp_d;
         drop_q     <= drop_d;
      end
   end

   assign c_req       = (state_q == ST_ISSUE);
   assign c_op        = c_op_q;
   assign c_addr      = c_addr_q;
   assign rd_cnt      = rd_q;
   assign wr_cnt      = wr_q;
   assign hit_cnt     = hit_q;
   assign miss_cnt    = miss_q;
   assign snoop_cnt   = snp_q;
   assign drop_cnt    = drop_q;
   assign stats_valid = stats_fire;
   assign busy        = !fifo_empty || c_req;

endmodule
